fifo_rd_check: RTL and testbench

FIFO_RD_CHECK -- requirements
Module: fifo_rd_check

---
 rtl/fifo_test_pkg.sv | 15 +
 rtl/sat_counter.sv | 17 +
 rtl/fifo_rd_check.sv | 134 +++++++++++++
 tb/tb_fifo_rd_check.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_test_pkg.sv
// Shared types and default sizing for the FIFO read-side pattern checker.
package fifo_test_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    READ      = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CNT_W     = 10;
  localparam int DEF_BURST_LEN = 128;

endpackage

// File: rtl/sat_counter.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fifo_rd_check.sv
// Reads bursts from a FIFO and checks the data against an incrementing pattern.
// Build option FIFO_RD_FWFT_EN: FIFO is first-word-fall-through (data valid with rd_en).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | just out of reset, moves on after one clock
// WAIT_FILL | waiting for a full burst worth of words in the FIFO
// READ      | issuing reads, rd_en = !empty, until BURST_LEN reads issued
// DRAIN     | last read in flight; its word is checked, then burst_done
module fifo_rd_check
  import fifo_test_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              empty,
  input  logic [CNT_W-1:0]  rd_data_count,
  input  logic [DATA_W-1:0] dout,
  output logic              rd_en,
  output logic              burst_done,
  output logic [15:0]       err_cnt,
  output logic              err_flag,
  output logic              pass
);

  localparam logic [CNT_W-1:0] FILL_LVL = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(BURST_LEN - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [DATA_W-1:0] expected;
  logic              rd_fire;
  logic              last_rd;
  logic              word_vld;
  logic              mismatch;
  logic              done_set;

  assign rd_fire  = rd_en && !empty;
  assign last_rd  = (rd_cnt == LAST_RD);
  assign mismatch = word_vld && (dout != expected);

`ifdef FIFO_RD_FWFT_EN
  assign word_vld = rd_fire;
`else
  logic rd_en_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_en_q <= 1'b0;
    end else begin
      rd_en_q <= rd_fire;
    end
  end

  assign word_vld = rd_en_q;
`endif

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (rd_data_count >= FILL_LVL) begin
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en = !empty;
        if (rd_en && last_rd) begin
`ifdef FIFO_RD_FWFT_EN
          state_nxt = WAIT_FILL;
          done_set  = 1'b1;
`else
          state_nxt = DRAIN;
`endif
        end
      end
      DRAIN: begin
        // The final read always issues the cycle before DRAIN, so its word is valid now.
        state_nxt = WAIT_FILL;
        done_set  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      expected   <= '0;
      burst_done <= 1'b0;
      err_flag   <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_done <= done_set;
      if (state != READ) begin
        rd_cnt <= '0;
      end else if (rd_fire) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      // Expected free-runs so one bad word does not cascade into later errors.
      if (word_vld) begin
        expected <= expected + DATA_W'(1);
      end
      if (mismatch) begin
        err_flag <= 1'b1;
      end
      if (mismatch) begin
        pass <= 1'b0;
      end else if (burst_done) begin
        pass <= (err_cnt == 16'd0);
      end
    end
  end

  sat_counter u_err_cnt (
    .sys_clk (sys_clk),
    .rst     (rst),
    .inc     (mismatch),
    .count   (err_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_check.sv
// Scoreboard bench for fifo_rd_check: FIFO model driven by directed bursts, monitor checks each burst_done.
module tb_fifo_rd_check;
  import fifo_test_pkg::*;

  localparam int DATA_W    = 16;
  localparam int CNT_W     = 10;
  localparam int BURST     = 128;
  localparam int MEM_DEPTH = 1 << 17;
`ifdef FIFO_RD_FWFT_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  logic              sys_clk = 1'b0;
  logic              rst = 1'b0;
  logic              empty;
  logic [CNT_W-1:0]  rd_data_count;
  logic [DATA_W-1:0] dout;
  logic              rd_en;
  logic              burst_done;
  logic [15:0]       err_cnt;
  logic              err_flag;
  logic              pass;

  fifo_rd_check #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .BURST_LEN (BURST)
  ) u_dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .empty         (empty),
    .rd_data_count (rd_data_count),
    .dout          (dout),
    .rd_en         (rd_en),
    .burst_done    (burst_done),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag),
    .pass          (pass)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: linear memory with read/write pointers
  logic [DATA_W-1:0] fifo_mem [MEM_DEPTH];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   occ;
  logic force_empty = 1'b0;

  always_comb begin
    occ           = wr_ptr - rd_ptr;
    empty         = (occ == 0) || force_empty;
    rd_data_count = (occ > 1023) ? CNT_W'(1023) : CNT_W'(occ);
  end

`ifdef FIFO_RD_FWFT_EN
  assign dout = fifo_mem[rd_ptr % MEM_DEPTH];
  always @(posedge sys_clk) begin
    if (rd_en && !empty) rd_ptr <= rd_ptr + 1;
  end
`else
  always @(posedge sys_clk) begin
    if (rd_en && !empty) begin
      rd_ptr <= rd_ptr + 1;
      dout   <= fifo_mem[rd_ptr % MEM_DEPTH];
    end
  end
`endif

  typedef struct {
    int          rd_cycles;
    int          gap;
    logic [15:0] err_cnt;
    logic        err_flag;
    logic        pass;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   viol = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per burst_done
  initial begin
    exp_t e;
    int   cyc = 0;
    int   rd_seen = 0;
    int   last_rd_cyc = 0;
    logic pass_pend = 1'b0;
    logic pass_exp = 1'b0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (rst) begin
        rd_seen   = 0;
        pass_pend = 1'b0;
      end else begin
        if (pass_pend) begin
          check("pass_after_burst", pass, pass_exp);
          pass_pend = 1'b0;
        end
        if (rd_en && empty) viol++;
        if (rd_en) begin
          rd_seen++;
          last_rd_cyc = cyc;
        end
        if (burst_done) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_burst_done: got burst_done=1 expected none at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            check("rd_en_cycles", rd_seen, e.rd_cycles);
            check("done_latency", cyc - last_rd_cyc, e.gap);
            check("err_cnt", err_cnt, e.err_cnt);
            check("err_flag", err_flag, e.err_flag);
            pass_exp  = e.pass;
            pass_pend = 1'b1;
          end
          rd_seen = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_mem[wr_ptr % MEM_DEPTH] = w;
    wr_ptr++;
  endtask

  task automatic expect_burst(input logic [15:0] ec, input logic ef, input logic p);
    sb_q.push_back('{rd_cycles: BURST, gap: EXP_GAP, err_cnt: ec, err_flag: ef, pass: p});
  endtask

  task automatic wait_bursts(input int n, input int budget);
    int target;
    int k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge sys_clk); #1;
      k++;
    end
    check("burst_count", done_cnt, target);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_reads(input int start, input int n, input int budget);
    int k;
    k = 0;
    while ((rd_ptr - start) < n && k < budget) begin
      @(posedge sys_clk); #1;
      k++;
    end
    check("read_progress", rd_ptr - start, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_burst_done"}, burst_done, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_err_flag"}, err_flag, 0);
    check({tag, "_pass"}, pass, 0);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    rst = 1'b1;
    wr_ptr = rd_ptr;
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int start;
    int saved;
    #1 rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");

    // Clean burst 0..127
    for (int i = 0; i < BURST; i++) push_word(DATA_W'(i));
    expect_burst(16'd0, 1'b0, 1'b1);
    rst = 1'b0;
    wait_bursts(1, 400);

    // Burst 128..255 with a 10-cycle empty stall after word 40
    start = rd_ptr;
    for (int i = 128; i < 256; i++) push_word(DATA_W'(i));
    expect_burst(16'd0, 1'b0, 1'b1);
    wait_reads(start, 41, 400);
    force_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_rd_en", rd_en, 0);
      @(posedge sys_clk); #1;
    end
    force_empty = 1'b0;
    check("stall_no_reads", rd_ptr - start, 41);
    wait_bursts(1, 400);

    // Pattern runs 256..65535 then wraps to 0..127
    for (int v = 256; v < 65536 + BURST; v++) push_word(DATA_W'(v));
    for (int b = 0; b < (65536 + BURST - 256) / BURST; b++) expect_burst(16'd0, 1'b0, 1'b1);
    wait_bursts((65536 + BURST - 256) / BURST, 72000);

    // Word 5 corrupted
    do_reset();
    for (int i = 0; i < BURST; i++) push_word((i == 5) ? 16'hDEAD : DATA_W'(i));
    expect_burst(16'd1, 1'b1, 1'b0);
    rst = 1'b0;
    wait_bursts(1, 400);

    // Reset in the middle of a burst, then a clean burst from 0
    do_reset();
    start = rd_ptr;
    for (int i = 0; i < BURST; i++) push_word(DATA_W'(i));
    rst = 1'b0;
    wait_reads(start, 60, 400);
    rst = 1'b1;
    saved = done_cnt;
    wr_ptr = rd_ptr;
    check_reset_outputs("midburst_reset");
    repeat (5) @(posedge sys_clk);
    #1;
    check("no_done_after_abort", done_cnt, saved);
    for (int i = 0; i < BURST; i++) push_word(DATA_W'(i));
    expect_burst(16'd0, 1'b0, 1'b1);
    rst = 1'b0;
    wait_bursts(1, 400);

    repeat (3) @(posedge sys_clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    check("rd_en_while_empty", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
